// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq: queues (reg,val) requests and issues paced OPL address/data writes, counted in cen ticks.
// Define JTOPL_WRSEQ_SKIPADDR_EN to skip the address write when the register is already selected.
module jtopl_wrseq #(
  parameter int FIFO_AW   = 2,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [7:0]         req_reg,
  input  logic [7:0]         req_val,
  output logic               wr,
  output logic               addr,
  output logic [7:0]         dout,
  output logic               busy,
  output logic [FIFO_AW:0]   level
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [2:0] {IDLE, ADDR, AWAIT, DATA, DWAIT} state_t;
  state_t st_q, st_d;
  logic [15:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0] lvl_q, lvl_d;
  logic [7:0] cnt_q, cnt_d, reg_q, reg_d, val_q, val_d, dout_q, dout_d;
  logic wr_q, wr_d, addr_q, addr_d, push, take, skip, done;
  assign req_ready = lvl_q != (FIFO_AW+1)'(DEPTH);
  assign push = req_valid && req_ready;
  assign done = cen && cnt_q <= 8'd1;
  assign take = lvl_q != '0 && (st_q == IDLE || (st_q == DWAIT && done));
  assign lvl_d = lvl_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(take);
  assign busy = lvl_q != '0 || st_q != IDLE;
  assign level = lvl_q;
  assign wr = wr_q;
  assign addr = addr_q;
  assign dout = dout_q;
`ifdef JTOPL_WRSEQ_SKIPADDR_EN
  logic [7:0] last_q;
  logic lv_q;
  assign skip = lv_q && mem_q[rp_q][15:8] == last_q;
  always_ff @(posedge clk)
    if (rst) lv_q <= 1'b0;
    else if (st_q == ADDR) begin
      last_q <= reg_q;
      lv_q <= 1'b1;
    end
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    {reg_d, val_d} = take ? mem_q[rp_q] : {reg_q, val_q};
    case (st_q)
      IDLE:  st_d = take ? (skip ? DATA : ADDR) : IDLE;
      ADDR: begin
        st_d = AWAIT;
        cnt_d = 8'(ADDR_WAIT);
      end
      AWAIT: begin
        cnt_d = cen ? cnt_q - 8'd1 : cnt_q;
        st_d = done ? DATA : AWAIT;
      end
      DATA: begin
        st_d = DWAIT;
        cnt_d = 8'(DATA_WAIT);
      end
      DWAIT: begin
        cnt_d = cen ? cnt_q - 8'd1 : cnt_q;
        st_d = !done ? DWAIT : take ? (skip ? DATA : ADDR) : IDLE;
      end
      default: st_d = IDLE;
    endcase
    wr_d = st_d == ADDR || st_d == DATA;
    addr_d = st_d == ADDR ? 1'b0 : st_d == DATA ? 1'b1 : addr_q;
    dout_d = st_d == ADDR ? reg_d : st_d == DATA ? val_d : dout_q;
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= {req_reg, req_val};
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      lvl_q <= '0;
      cnt_q <= '0;
      reg_q <= '0;
      val_q <= '0;
      wr_q <= 1'b0;
      addr_q <= 1'b0;
      dout_q <= '0;
    end else begin
      st_q <= st_d;
      wp_q <= wp_q + FIFO_AW'(push);
      rp_q <= rp_q + FIFO_AW'(take);
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      reg_q <= reg_d;
      val_q <= val_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
    end
endmodule
